ula_mc: RTL and testbench



---
 rtl/ula_mc_pkg.sv | 26 ++
 rtl/ula_muldiv_iter.sv | 87 ++++++++
 rtl/ula_mc.sv | 174 +++++++++++++++++
 tb/tb_ula_mc.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_mc_pkg.sv
// Shared constants for the execute-stage ALU: opcode encodings, flag bit
// positions and the controller state encoding.
package ula_mc_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_CMP = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_DIV = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;

    localparam int FLAG_OVF = 4;
    localparam int FLAG_GT  = 3;
    localparam int FLAG_EQ  = 2;
    localparam int FLAG_LT  = 1;
    localparam int FLAG_DZ  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_muldiv_iter.sv
// Iterative unsigned datapath shared by multiply (shift-add) and divide
// (restoring). One iteration per cycle for DATA_WIDTH cycles after start.
module ula_muldiv_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a_mag,
    input  logic [DATA_WIDTH-1:0] b_mag,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] hi,
    output logic                  done
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    logic          active;
    logic          div_mode;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  b_reg;

    logic [W:0]    add_sum;
    logic [W:0]    part;
    logic [W:0]    shifted;
    logic [W-1:0]  sub_res;
    logic          fits;
    logic [W-1:0]  nxt_hi;
    logic [W-1:0]  nxt_lo;

    // acc_hi holds the running product high half or the partial remainder;
    // acc_lo holds the multiplier being shifted out or the quotient shifting in.
    assign add_sum = {1'b0, acc_hi} + {1'b0, b_reg};
    assign part    = acc_lo[0] ? add_sum : {1'b0, acc_hi};
    assign shifted = {acc_hi, acc_lo[W-1]};
    assign sub_res = shifted[W-1:0] - b_reg;
    assign fits    = shifted >= {1'b0, b_reg};

    always_comb begin
        nxt_hi = '0;
        nxt_lo = '0;
        if (div_mode) begin
            nxt_hi = fits ? sub_res : shifted[W-1:0];
            nxt_lo = {acc_lo[W-2:0], fits};
        end else begin
            nxt_hi = part[W:1];
            nxt_lo = {part[0], acc_lo[W-1:1]};
        end
    end

    // Outputs present the post-iteration values so the caller can capture
    // the final result on the same edge as the last iteration.
    assign result = nxt_lo;
    assign hi     = nxt_hi;
    assign done   = active && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active   <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            b_reg    <= '0;
        end else if (start) begin
            active   <= 1'b1;
            div_mode <= is_div;
            cnt      <= CW'(DATA_WIDTH - 1);
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            b_reg    <= b_mag;
        end else if (active) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle execute-stage ALU behind valid/ready handshakes. Single-cycle
// ops finish on the accept edge; signed MUL/DIV run on the shared iterator.
//
//   state  | meaning
//   IDLE   | in_ready high, waiting for an operation
//   BUSY   | MUL/DIV iterating, one step per cycle
//   DONE   | out/rflags valid and held until out_ready
module ula_mc
    import ula_mc_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   data1,
    input  logic [DATA_WIDTH-1:0]   data2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out,
    output logic [4:0]              rflags
);

    localparam int W = DATA_WIDTH;

    state_t        state;
    logic          neg_r;
    logic          is_div_r;

    logic [W-1:0]  mag1;
    logic [W-1:0]  mag2;
    logic          is_mul_op;
    logic          is_div_op;
    logic          div_zero;
    logic          needs_iter;
    logic          start;

    logic [W-1:0]  sum;
    logic [W-1:0]  diff;
    logic          add_ovf;
    logic          sub_ovf;
    logic [W-1:0]  sc_out;
    logic [4:0]    sc_flags;

    logic [W-1:0]  it_lo;
    logic [W-1:0]  it_hi;
    logic          it_done;
    logic [2*W-1:0] prod_mag;
    logic [2*W-1:0] prod_s;
    logic [W:0]    prod_top;
    logic [W-1:0]  quo_s;
    logic [W-1:0]  md_out;
    logic [4:0]    md_flags;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    assign mag1 = data1[W-1] ? (~data1 + W'(1)) : data1;
    assign mag2 = data2[W-1] ? (~data2 + W'(1)) : data2;

    assign is_mul_op  = (opcode == OPCODE_WIDTH'(OP_MUL));
    assign is_div_op  = (opcode == OPCODE_WIDTH'(OP_DIV));
    assign div_zero   = (data2 == '0);
    assign needs_iter = is_mul_op || (is_div_op && !div_zero);
    assign start      = in_ready && in_valid && needs_iter;

    assign sum     = data1 + data2;
    assign diff    = data1 - data2;
    assign add_ovf = (data1[W-1] == data2[W-1]) && (sum[W-1] != data1[W-1]);
    assign sub_ovf = (data1[W-1] != data2[W-1]) && (diff[W-1] != data1[W-1]);

    always_comb begin
        sc_out   = '0;
        sc_flags = '0;
        case (opcode)
            OPCODE_WIDTH'(OP_ADD): begin
                sc_out             = sum;
                sc_flags[FLAG_OVF] = add_ovf;
            end
            OPCODE_WIDTH'(OP_SUB): begin
                sc_out             = diff;
                sc_flags[FLAG_OVF] = sub_ovf;
            end
            OPCODE_WIDTH'(OP_CMP): begin
                // Ordering comes from the true signed compare, not the
                // (possibly overflowed) difference.
                sc_out             = diff;
                sc_flags[FLAG_OVF] = sub_ovf;
                sc_flags[FLAG_GT]  = $signed(data1) > $signed(data2);
                sc_flags[FLAG_EQ]  = data1 == data2;
                sc_flags[FLAG_LT]  = $signed(data1) < $signed(data2);
            end
            OPCODE_WIDTH'(OP_AND): sc_out = data1 & data2;
            OPCODE_WIDTH'(OP_OR):  sc_out = data1 | data2;
            OPCODE_WIDTH'(OP_NOT): sc_out = (data1 == '0) ? W'(1) : '0;
            OPCODE_WIDTH'(OP_DIV): sc_flags[FLAG_DZ] = 1'b1;
            default: ;
        endcase
    end

    ula_muldiv_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .is_div (is_div_op),
        .a_mag  (mag1),
        .b_mag  (mag2),
        .result (it_lo),
        .hi     (it_hi),
        .done   (it_done)
    );

    assign prod_mag = {it_hi, it_lo};
    assign prod_s   = neg_r ? (~prod_mag + (2*W)'(1)) : prod_mag;
    assign prod_top = prod_s[2*W-1:W-1];
    assign quo_s    = neg_r ? (~it_lo + W'(1)) : it_lo;

    // A positive quotient of magnitude 2^(W-1) only arises from MIN / -1.
    always_comb begin
        md_flags = '0;
        if (is_div_r) begin
            md_out             = quo_s;
            md_flags[FLAG_OVF] = !neg_r && it_lo[W-1];
        end else begin
            md_out             = prod_s[W-1:0];
            md_flags[FLAG_OVF] = !((&prod_top) || (prod_top == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            out      <= '0;
            rflags   <= '0;
            neg_r    <= 1'b0;
            is_div_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (needs_iter) begin
                            state    <= S_BUSY;
                            neg_r    <= data1[W-1] ^ data2[W-1];
                            is_div_r <= is_div_op;
                        end else begin
                            state  <= S_DONE;
                            out    <= sc_out;
                            rflags <= sc_flags;
                        end
                    end
                end
                S_BUSY: begin
                    if (it_done) begin
                        state  <= S_DONE;
                        out    <= md_out;
                        rflags <= md_flags;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_mc.sv
// Self-checking bench for ula_mc: directed vectors with literal expectations
// plus an arithmetic reference model checked every cycle by a monitor.
module tb_ula_mc
    import ula_mc_pkg::*;
;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [4:0]   rflags;

    ula_mc #(.DATA_WIDTH(W), .OPCODE_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .rflags    (rflags)
    );

    typedef struct {
        logic [W-1:0] o;
        logic [4:0]   f;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] last_out = '0;
    logic [4:0]   last_flags = '0;
    int           last_lat = -1;
    bit           seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: plain signed arithmetic on wide integers.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] o,
                                  output logic [4:0] f, output int lat);
        longint sa, sb, r, mx, mn;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        mx  = (longint'(1) <<< (W - 1)) - 1;
        mn  = -(longint'(1) <<< (W - 1));
        f   = '0;
        lat = 0;
        r   = 0;
        case (op)
            OP_ADD: begin r = sa + sb; f[FLAG_OVF] = (r > mx) || (r < mn); end
            OP_SUB, OP_CMP: begin
                r = sa - sb;
                f[FLAG_OVF] = (r > mx) || (r < mn);
                if (op == OP_CMP) begin
                    f[FLAG_GT] = sa > sb;
                    f[FLAG_EQ] = sa == sb;
                    f[FLAG_LT] = sa < sb;
                end
            end
            OP_MUL: begin r = sa * sb; f[FLAG_OVF] = (r > mx) || (r < mn); lat = W; end
            OP_DIV: begin
                if (sb == 0) f[FLAG_DZ] = 1'b1;
                else begin r = sa / sb; f[FLAG_OVF] = (r > mx) || (r < mn); lat = W; end
            end
            OP_AND: r = longint'(a & b);
            OP_OR:  r = longint'(a | b);
            OP_NOT: r = (a == '0) ? 1 : 0;
            default: r = 0;
        endcase
        o = r[W-1:0];
    endfunction

    // Per-cycle compare of handshake and result against the expectation queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            bit exp_v;
            exp_v = 1'b0;
            if (q.size() != 0) exp_v = (cyc - q[0].acc) >= q[0].lat;
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            if (out_valid && q.size() != 0) begin
                if (!seen) begin
                    last_lat = cyc - q[0].acc;
                    seen = 1;
                end
                chk("out", 32'(out), 32'(q[0].o));
                chk("rflags", 32'(rflags), 32'(q[0].f));
                if (out_ready) begin
                    last_out   = out;
                    last_flags = rflags;
                    seen       = 0;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] mo;
        logic [4:0]   mf;
        int           ml;
        bit           ok;
        model(op, a, b, mo, mf, ml);
        @(posedge clk); #1;
        in_valid = 1'b1;
        opcode   = op;
        data1    = a;
        data2    = b;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready never rose, op %0h", op);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        q.push_back('{o: mo, f: mf, acc: cyc, lat: ml});
        in_valid = 1'b0;
        data1    = W'($urandom);
        data2    = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (q.size() == 0) return;
        end
        n_checks++; n_fail++;
        $display("FAIL result_timeout: %0d results outstanding", q.size());
        q.delete();
    endtask

    task automatic run_lit(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eo,
                           input logic [4:0] ef, input int elat);
        logic [W-1:0] mo;
        logic [4:0]   mf;
        int           ml;
        model(op, a, b, mo, mf, ml);
        chk({nm, " model_out"}, 32'(mo), 32'(eo));
        chk({nm, " model_flags"}, 32'(mf), 32'(ef));
        do_op(op, a, b);
        wait_idle();
        chk({nm, " out"}, 32'(last_out), 32'(eo));
        chk({nm, " flags"}, 32'(last_flags), 32'(ef));
        chk({nm, " latency"}, 32'(last_lat), 32'(elat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        data1     = '0;
        data2     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out", 32'(out), 32'd0);
        chk("reset rflags", 32'(rflags), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_lit("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b10000, 0);
        run_lit("cmp_min",  OP_CMP, 16'h8000, 16'h0001, 16'h7FFF, 5'b10010, 0);
        run_lit("cmp_eq",   OP_CMP, 16'h0005, 16'h0005, 16'h0000, 5'b00100, 0);
        run_lit("cmp_gt",   OP_CMP, 16'h0003, 16'hFFFE, 16'h0005, 5'b01000, 0);
        run_lit("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b10000, 0);
        run_lit("mul_neg",  OP_MUL, 16'hFFFD, 16'h0007, 16'hFFEB, 5'b00000, 16);
        run_lit("mul_ovf",  OP_MUL, 16'h0100, 16'h0100, 16'h0000, 5'b10000, 16);
        run_lit("mul_min",  OP_MUL, 16'h8000, 16'h0001, 16'h8000, 5'b00000, 16);
        run_lit("mul_minn", OP_MUL, 16'h8000, 16'hFFFF, 16'h8000, 5'b10000, 16);
        run_lit("div_neg",  OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 5'b00000, 16);
        run_lit("div_zero", OP_DIV, 16'h0009, 16'h0000, 16'h0000, 5'b00001, 0);
        run_lit("div_ovf",  OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 5'b10000, 16);
        run_lit("div_mix",  OP_DIV, 16'h0064, 16'hFFF9, 16'hFFF2, 5'b00000, 16);
        run_lit("and",      OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000, 0);
        run_lit("or",       OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 5'b00000, 0);
        run_lit("not_zero", OP_NOT, 16'h0000, 16'h1234, 16'h0001, 5'b00000, 0);
        run_lit("not_nz",   OP_NOT, 16'h0005, 16'h0000, 16'h0000, 5'b00000, 0);
        run_lit("unknown",  4'hF,   16'h1234, 16'h5678, 16'h0000, 5'b00000, 0);

        // Backpressure: result held while out_ready is low; new request ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_op(OP_ADD, 16'h0001, 16'h0002);
        @(posedge clk); #1;
        in_valid = 1'b1;
        opcode   = OP_OR;
        data1    = 16'h00A0;
        data2    = 16'h000B;
        repeat (5) begin
            @(negedge clk);
            chk("bp out", 32'(out), 32'h3);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        do_op(OP_OR, 16'h00A0, 16'h000B);
        wait_idle();
        chk("bp next out", 32'(last_out), 32'h00AB);

        // Reset in the middle of a multiply abandons it.
        do_op(OP_MUL, 16'h1234, 16'h0042);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        seen = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out", 32'(out), 32'd0);
        chk("midrst rflags", 32'(rflags), 32'd0);
        repeat (20) @(posedge clk);
        run_lit("post_rst", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 0);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 8));
            if (op == 4'd8) op = 4'hC;
            a = W'($urandom);
            b = W'($urandom);
            if (i % 7 == 3) b = '0;
            if (i % 5 == 1) a = 16'h8000;
            if (i % 6 == 2) b = W'($urandom_range(1, 9));
            do_op(op, a, b);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
